projection_mem_ctrl: RTL and testbench
======================================

PROJECTION_MEM_CTRL -- requirements
Module: projection_mem_ctrl

Interface
REQ-001 SHALL have parameter DHV_SIZE, default 4000: hypervector dimension in bits.
REQ-002 SHALL have parameter IN_WIDTH, default 16: bits per memory word.
REQ-003 SHALL have parameter LANES, default 2: words written per accepted load beat (1..8).
REQ-004 SHALL have parameter RD_PORTS, default 2: independent read ports (1..4).
REQ-005 SHALL derive localparams DEPTH = ceil(DHV_SIZE/IN_WIDTH) (250 at defaults), ADDR_WIDTH = $clog2(DEPTH), BEATS = ceil(DEPTH/LANES) (125 at defaults).
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-low (asserted at 0); deassertion synchronised by the integrator.
REQ-008 load_start  input  1  one-cycle pulse: begin (or restart) a full memory load.
REQ-009 in_valid  input  1  load beat present on in_data.
REQ-010 in_ready  output  1  controller accepts a beat this cycle.
REQ-011 in_data  input  [LANES][IN_WIDTH]  lane i written to address wr_ptr+i.
REQ-012 load_done  output  1  level, high while memory holds a complete load.
REQ-013 busy  output  1  high while in LOAD.
REQ-014 rd_en  input  [RD_PORTS]  per-port read request.
REQ-015 rd_addr  input  [RD_PORTS][ADDR_WIDTH]  per-port word address.
REQ-016 rd_data  output  [RD_PORTS][IN_WIDTH]  registered read data.
REQ-017 rd_valid  output  [RD_PORTS]  rd_data valid this cycle.
REQ-018 rd_err  output  [RD_PORTS]  one-cycle pulse: rejected read.

Function
REQ-019 FSM SHALL have states IDLE, LOAD, READY; IDLE after reset.
REQ-020 load_start in any state SHALL go to LOAD next cycle, clearing wr_ptr to 0 and load_done to 0; a beat presented that same cycle SHALL be discarded.
REQ-021 in_ready SHALL be 1 only in LOAD and not in a cycle where load_start is high.
REQ-022 Beat accepted when in_valid & in_ready; lane i written to wr_ptr+i only if wr_ptr+i < DEPTH, excess lanes of the final beat dropped.
REQ-023 wr_ptr SHALL advance by LANES per accepted beat; no advance without acceptance (backpressure-tolerant, gaps allowed).
REQ-024 Acceptance of beat BEATS SHALL move LOAD->READY and set load_done=1 on the next edge.
REQ-025 Reads SHALL be serviced only in READY: rd_en & rd_addr<DEPTH gives rd_data = mem[rd_addr] and rd_valid=1 exactly one cycle later.
REQ-026 rd_en in IDLE/LOAD or with rd_addr>=DEPTH SHALL give rd_valid=0, rd_err=1 one cycle later; rd_data SHALL hold its prior value.
REQ-027 Ports SHALL be independent; identical addresses on several ports SHALL all return the same word.
REQ-028 rd_en=0 SHALL give rd_valid=0, rd_err=0 next cycle, rd_data held.
REQ-029 Memory contents SHALL persist across READY->LOAD until overwritten.

Reset
REQ-030 reset=0 SHALL immediately force state IDLE, wr_ptr=0, in_ready=0, busy=0, load_done=0, rd_valid=0, rd_err=0, rd_data=0.
REQ-031 Reset mid-load SHALL abandon the load; memory contents undefined, not cleared.

Structure
REQ-032 Package proj_mem_pkg SHALL hold the FSM state enum and default DHV_SIZE/IN_WIDTH constants.
REQ-033 Storage SHALL be sub-module memory_multi (LANES write ports, RD_PORTS registered read ports); FSM, pointer and read gating in projection_mem_ctrl.

Verification
REQ-034 Defaults, load_start, 125 beats with lane i = wr_ptr+i -> load_done=1 the cycle after beat 125; reads 0..249 on both ports return address value, latency 1.
REQ-035 in_valid toggled 1/0 every cycle -> still 125 accepted beats, identical contents, load_done after last acceptance.
REQ-036 DHV_SIZE=48, IN_WIDTH=16, LANES=2 -> DEPTH=3, BEATS=2; beat 2 lane 1 dropped; read addr 3 -> rd_err=1, rd_valid=0.
REQ-037 rd_en during LOAD at addr 5 -> rd_err=1 next cycle; load_start in READY -> load_done=0, reads rejected until reload completes.
REQ-038 reset=0 after beat 60 -> all outputs 0 immediately; new load_start then 125 beats completes normally.
REQ-039 Both ports read addr 7 in same cycle -> both rd_valid=1 with data 7.

Source files
------------

// File: rtl/proj_mem_pkg.sv
// proj_mem_pkg
//   Shared definitions for the projection memory controller: default
//   hypervector geometry, the controller state encoding and a ceiling-divide
//   helper used to size memory depth and load beat count.
package proj_mem_pkg;

    localparam int unsigned DEF_DHV_SIZE = 4000;
    localparam int unsigned DEF_IN_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/memory_multi.sv
// memory_multi
//   Word-addressed storage with LANES independent write ports and RD_PORTS
//   registered read ports. The storage array has no reset (contents survive
//   a reset); only the read data registers are cleared.
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_wr_en/i_wr_addr/i_wr_data per-lane write port
//   i_rd_en/i_rd_addr           per-port read request (caller keeps addr < DEPTH)
//   o_rd_data                   per-port read data, held when not enabled
module memory_multi
    import proj_mem_pkg::*;
#(
    parameter int unsigned DEPTH      = 250,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
    parameter int unsigned LANES      = 2,
    parameter int unsigned RD_PORTS   = 2
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [LANES-1:0]                     i_wr_en,
    input  logic [LANES-1:0][ADDR_WIDTH-1:0]     i_wr_addr,
    input  logic [LANES-1:0][IN_WIDTH-1:0]       i_wr_data,
    input  logic [RD_PORTS-1:0]                  i_rd_en,
    input  logic [RD_PORTS-1:0][ADDR_WIDTH-1:0]  i_rd_addr,
    output logic [RD_PORTS-1:0][IN_WIDTH-1:0]    o_rd_data
);

    logic [IN_WIDTH-1:0]                  r_mem [DEPTH];
    logic [RD_PORTS-1:0][IN_WIDTH-1:0]    r_rd_data;

    always_ff @(posedge i_clk) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (i_wr_en[i]) begin
                r_mem[i_wr_addr[i]] <= i_wr_data[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else begin
            for (int unsigned p = 0; p < RD_PORTS; p++) begin
                if (i_rd_en[p]) begin
                    r_rd_data[p] <= r_mem[i_rd_addr[p]];
                end
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/projection_mem_ctrl.sv
// projection_mem_ctrl
//   Loads a projection hypervector memory in LANES-wide beats and serves
//   RD_PORTS independent registered reads once a complete load is held.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   load_start                 pulse: (re)start a full load, discards same-cycle beat
//   in_valid/in_ready/in_data  load beat handshake, lane i -> wr_ptr+i
//   load_done                  level: memory holds a complete load
//   busy                       loading in progress
//   rd_en/rd_addr              per-port read request
//   rd_data/rd_valid/rd_err    per-port result one cycle after the request
module projection_mem_ctrl
    import proj_mem_pkg::*;
#(
    parameter  int unsigned DHV_SIZE   = DEF_DHV_SIZE,
    parameter  int unsigned IN_WIDTH   = DEF_IN_WIDTH,
    parameter  int unsigned LANES      = 2,
    parameter  int unsigned RD_PORTS   = 2,
    localparam int unsigned DEPTH      = ceil_div(DHV_SIZE, IN_WIDTH),
    localparam int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned BEATS      = ceil_div(DEPTH, LANES)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 load_start,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LANES-1:0][IN_WIDTH-1:0]       in_data,
    output logic                                 load_done,
    output logic                                 busy,
    input  logic [RD_PORTS-1:0]                  rd_en,
    input  logic [RD_PORTS-1:0][ADDR_WIDTH-1:0]  rd_addr,
    output logic [RD_PORTS-1:0][IN_WIDTH-1:0]    rd_data,
    output logic [RD_PORTS-1:0]                  rd_valid,
    output logic [RD_PORTS-1:0]                  rd_err
);

    // Pointer must reach BEATS*LANES, which may exceed DEPTH on a ragged last beat.
    localparam int unsigned        PTR_W   = $clog2(BEATS * LANES + 1);
    localparam logic [PTR_W-1:0]   DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0]   LANES_P = PTR_W'(LANES);
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                                r_state;
    logic [PTR_W-1:0]                      r_wr_ptr;
    logic                                  r_load_done;
    logic [RD_PORTS-1:0]                   r_rd_valid;
    logic [RD_PORTS-1:0]                   r_rd_err;

    logic                                  w_in_ready;
    logic                                  w_accept;
    logic                                  w_last;
    logic [LANES-1:0]                      w_wr_en;
    logic [LANES-1:0][ADDR_WIDTH-1:0]      w_wr_addr;
    logic [RD_PORTS-1:0]                   w_rd_ok;

    assign w_in_ready = (r_state == ST_LOAD) && !load_start;
    assign w_accept   = in_valid && w_in_ready;
    assign w_last     = (r_wr_ptr + LANES_P) >= DEPTH_P;

    // Lanes past the end of memory on the final beat are dropped.
    always_comb begin
        w_wr_en   = '0;
        w_wr_addr = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_wr_en[i]   = w_accept && ((r_wr_ptr + PTR_W'(i)) < DEPTH_P);
            w_wr_addr[i] = ADDR_WIDTH'(r_wr_ptr + PTR_W'(i));
        end
    end

    always_comb begin
        w_rd_ok = '0;
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            w_rd_ok[p] = (r_state == ST_READY) && ({1'b0, rd_addr[p]} < DEPTH_A);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_load_done <= 1'b0;
        end else if (load_start) begin
            r_state     <= ST_LOAD;
            r_wr_ptr    <= '0;
            r_load_done <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_wr_ptr <= r_wr_ptr + LANES_P;
                        if (w_last) begin
                            r_state     <= ST_READY;
                            r_load_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_valid <= '0;
            r_rd_err   <= '0;
        end else begin
            r_rd_valid <= rd_en & w_rd_ok;
            r_rd_err   <= rd_en & ~w_rd_ok;
        end
    end

    memory_multi #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IN_WIDTH   (IN_WIDTH),
        .LANES      (LANES),
        .RD_PORTS   (RD_PORTS)
    ) u_mem (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (w_wr_addr),
        .i_wr_data  (in_data),
        .i_rd_en    (rd_en & w_rd_ok),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data)
    );

    assign in_ready  = w_in_ready;
    assign busy      = (r_state == ST_LOAD);
    assign load_done = r_load_done;
    assign rd_valid  = r_rd_valid;
    assign rd_err    = r_rd_err;

endmodule

// File: tb/tb_projection_mem_ctrl.sv
// tb_projection_mem_ctrl
//   Randomized bench for projection_mem_ctrl at default geometry, checked
//   against a word-array reference model, plus a directed pass on a 3-word
//   instance exercising the ragged final beat and out-of-range reads.
module tb_projection_mem_ctrl;

    localparam int DEPTH = 250;
    localparam int LANES = 2;
    localparam int RP    = 2;
    localparam int AW    = 8;
    localparam int W     = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic                     load_start, in_valid, in_ready, load_done, busy;
    logic [LANES-1:0][W-1:0]  in_data;
    logic [RP-1:0]            rd_en, rd_valid, rd_err;
    logic [RP-1:0][AW-1:0]    rd_addr;
    logic [RP-1:0][W-1:0]     rd_data;

    logic                     s_load_start, s_in_valid, s_in_ready, s_load_done, s_busy;
    logic [1:0][15:0]         s_in_data;
    logic [1:0]               s_rd_en, s_rd_valid, s_rd_err;
    logic [1:0][1:0]          s_rd_addr;
    logic [1:0][15:0]         s_rd_data;

    projection_mem_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .load_done  (load_done),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err)
    );

    projection_mem_ctrl #(
        .DHV_SIZE (48),
        .IN_WIDTH (16),
        .LANES    (2),
        .RD_PORTS (2)
    ) dut_s (
        .clk        (clk),
        .reset      (reset),
        .load_start (s_load_start),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_data    (s_in_data),
        .load_done  (s_load_done),
        .busy       (s_busy),
        .rd_en      (s_rd_en),
        .rd_addr    (s_rd_addr),
        .rd_data    (s_rd_data),
        .rd_valid   (s_rd_valid),
        .rd_err     (s_rd_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: memory image, load progress and expected read results.
    logic [W-1:0] m_mem [DEPTH];
    int           m_phase;      // 0 idle, 1 loading, 2 complete load held
    int           m_ptr;
    bit           m_done;
    logic [RP-1:0] e_rv, e_re;
    logic [W-1:0]  e_rd [RP];

    // Inputs for this cycle are already driven; check outputs, advance model, move to next negedge.
    task automatic tick();
        #1;
        check_eq("busy", busy, 32'(m_phase == 1));
        check_eq("load_done", load_done, 32'(m_done));
        check_eq("in_ready", in_ready, 32'((m_phase == 1) && !load_start));
        for (int p = 0; p < RP; p++) begin
            check_eq($sformatf("rd_valid%0d", p), rd_valid[p], e_rv[p]);
            check_eq($sformatf("rd_err%0d", p), rd_err[p], e_re[p]);
            check_eq($sformatf("rd_data%0d", p), rd_data[p], e_rd[p]);
        end
        for (int p = 0; p < RP; p++) begin
            e_rv[p] = 1'b0;
            e_re[p] = 1'b0;
            if (rd_en[p]) begin
                if (m_phase == 2 && int'(rd_addr[p]) < DEPTH) begin
                    e_rv[p] = 1'b1;
                    e_rd[p] = m_mem[rd_addr[p]];
                end else begin
                    e_re[p] = 1'b1;
                end
            end
        end
        if (load_start) begin
            m_phase = 1;
            m_ptr   = 0;
            m_done  = 0;
        end else if (m_phase == 1 && in_valid) begin
            for (int i = 0; i < LANES; i++)
                if (m_ptr + i < DEPTH) m_mem[m_ptr + i] = in_data[i];
            m_ptr += LANES;
            if (m_ptr >= DEPTH) begin
                m_phase = 2;
                m_done  = 1;
            end
        end
        @(negedge clk);
    endtask

    // mode 0: always valid, data = address; 1: valid toggles, data = address; 2: random valid and data.
    // cut > 0 stops after that many accepted beats, leaving the load unfinished.
    task automatic run_load(input int mode, input int cut);
        int beats = 0;
        int cyc   = 0;
        load_start = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < LANES; i++) in_data[i] = W'($urandom);
        rd_en      = '0;
        tick();
        load_start = 1'b0;
        while (m_phase == 1 && cyc < 2000) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2) == 0;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            for (int i = 0; i < LANES; i++)
                in_data[i] = (mode == 2) ? W'($urandom) : W'(m_ptr + i);
            rd_en = RP'($urandom);
            for (int p = 0; p < RP; p++) rd_addr[p] = AW'($urandom);
            if (in_valid) beats++;
            tick();
            cyc++;
            if (cut > 0 && beats >= cut) break;
        end
        in_valid = 1'b0;
        rd_en    = '0;
        if (cut == 0) begin
            check_eq("load_completed", load_done, 32'd1);
            tick();
        end
    endtask

    task automatic read_sweep();
        for (int k = 0; k < DEPTH; k++) begin
            rd_en      = '1;
            rd_addr[0] = AW'(k);
            rd_addr[1] = AW'(DEPTH - 1 - k);
            tick();
        end
        rd_en = '0;
        tick();
    endtask

    task automatic read_random(input int n);
        for (int k = 0; k < n; k++) begin
            rd_en = RP'($urandom);
            for (int p = 0; p < RP; p++) rd_addr[p] = AW'($urandom_range(0, 255));
            tick();
        end
        rd_en = '0;
        tick();
    endtask

    task automatic small_test();
        s_load_start = 1'b1;
        s_in_valid   = 1'b1;
        s_in_data[0] = 16'hBEEF;
        s_in_data[1] = 16'hDEAD;
        #1 check_eq("s_ready_on_start", s_in_ready, 32'd0);
        @(negedge clk);
        s_load_start = 1'b0;
        s_in_data[0] = 16'h00A0;
        s_in_data[1] = 16'h00A1;
        #1;
        check_eq("s_busy", s_busy, 32'd1);
        check_eq("s_in_ready", s_in_ready, 32'd1);
        @(negedge clk);
        s_in_data[0] = 16'h00A2;
        s_in_data[1] = 16'h00A3;
        #1 check_eq("s_done_early", s_load_done, 32'd0);
        @(negedge clk);
        s_in_valid = 1'b0;
        #1;
        check_eq("s_load_done", s_load_done, 32'd1);
        check_eq("s_busy_end", s_busy, 32'd0);
        s_rd_en      = 2'b11;
        s_rd_addr[0] = 2'd0;
        s_rd_addr[1] = 2'd2;
        @(negedge clk);
        #1;
        check_eq("s_rv_a", s_rd_valid, 32'h3);
        check_eq("s_rd0_addr0", s_rd_data[0], 32'h00A0);
        check_eq("s_rd1_addr2", s_rd_data[1], 32'h00A2);
        s_rd_addr[0] = 2'd1;
        s_rd_addr[1] = 2'd3;
        @(negedge clk);
        #1;
        check_eq("s_rv_b", s_rd_valid, 32'h1);
        check_eq("s_err_b", s_rd_err, 32'h2);
        check_eq("s_rd0_addr1", s_rd_data[0], 32'h00A1);
        check_eq("s_rd1_held", s_rd_data[1], 32'h00A2);
        s_rd_en = 2'b00;
        @(negedge clk);
        #1 check_eq("s_err_clear", s_rd_err, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b0;
        load_start   = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        rd_en        = '0;
        rd_addr      = '0;
        s_load_start = 1'b0;
        s_in_valid   = 1'b0;
        s_in_data    = '0;
        s_rd_en      = '0;
        s_rd_addr    = '0;
        m_phase      = 0;
        m_ptr        = 0;
        m_done       = 0;
        e_rv         = '0;
        e_re         = '0;
        for (int p = 0; p < RP; p++) e_rd[p] = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_busy", busy, 32'd0);
        check_eq("rst_load_done", load_done, 32'd0);
        check_eq("rst_in_ready", in_ready, 32'd0);
        check_eq("rst_rd_valid", rd_valid, 32'd0);
        check_eq("rst_rd_data", rd_data, 32'd0);
        check_eq("rst_s_busy", s_busy, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        small_test();

        // Reads before any load are rejected.
        rd_en = '1;
        rd_addr[0] = 8'd5;
        rd_addr[1] = 8'd200;
        tick();
        rd_en = '0;
        tick();

        run_load(0, 0);
        read_sweep();
        rd_en = '1;
        rd_addr[0] = 8'd7;
        rd_addr[1] = 8'd7;
        tick();
        rd_en = '0;
        tick();
        check_eq("same_addr_p0", rd_data[0], 32'd7);
        check_eq("same_addr_p1", rd_data[1], 32'd7);
        read_random(60);

        run_load(1, 0);
        read_sweep();

        run_load(2, 0);
        read_random(80);

        // Abandon a load part-way with an asynchronous reset.
        run_load(2, 60);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 32'd0);
        check_eq("mid_rst_in_ready", in_ready, 32'd0);
        check_eq("mid_rst_load_done", load_done, 32'd0);
        check_eq("mid_rst_rd_valid", rd_valid, 32'd0);
        check_eq("mid_rst_rd_err", rd_err, 32'd0);
        check_eq("mid_rst_rd_data", rd_data, 32'd0);
        m_phase = 0;
        m_done  = 0;
        e_rv    = '0;
        e_re    = '0;
        for (int p = 0; p < RP; p++) e_rd[p] = '0;
        #1 reset = 1'b1;
        @(negedge clk);
        read_random(4);

        run_load(2, 0);
        read_random(60);
        read_sweep();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
